alu_flag_deco: RTL and testbench

ALU_FLAG_DECO -- requirements
Module: alu_flag_deco

---
 rtl/alu_flag_deco_pkg.sv | 19 +
 rtl/alu_flag_deco_ffd.sv | 23 ++
 rtl/alu_flag_deco.sv | 58 +++++
 tb/tb_alu_flag_deco.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_flag_deco_pkg.sv
// Shared CPU definitions for the ALU/flag/decoder slice: operation encodings
// and decoder sizing.
package alu_flag_deco_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'b000,
    ALU_NOT_A  = 3'b001,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_NEG_A  = 3'b110,
    ALU_NEG_B  = 3'b111
  } alu_op_e;

  localparam int DEC_SEL_W = 2;
  localparam int DEC_WIDTH = 1 << DEC_SEL_W;

endpackage

// File: rtl/alu_flag_deco_ffd.sv
// Single-bit load-enabled flip-flop holding the zero flag; clears
// asynchronously while reset is low.
module ffd (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic load,
  output logic q
);

  logic q_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= 1'b0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/alu_flag_deco.sv
// Combinational ALU with zero detect, a registered zero flag, and a
// one-hot port-write decoder.
module alu_flag_deco
  import alu_flag_deco_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_alu,
  input  logic             wez,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             zalu,
  output logic             z,
  output logic [3:0]       dec
);

  logic [WIDTH-1:0] y_next;

  // Unknown select values fall through to zero rather than being propagated.
  always_comb begin
    y_next = '0;
    case (op_alu)
      ALU_PASS_A: y_next = a;
      ALU_NOT_A:  y_next = ~a;
      ALU_ADD:    y_next = a + b;
      ALU_SUB:    y_next = a - b;
      ALU_AND:    y_next = a & b;
      ALU_OR:     y_next = a | b;
      ALU_NEG_A:  y_next = -a;
      ALU_NEG_B:  y_next = -b;
      default:    y_next = '0;
    endcase
  end

  assign y    = y_next;
  assign zalu = ~|y_next;

  ffd u_zflag (
    .clk   (clk),
    .reset (reset),
    .d     (zalu),
    .load  (wez),
    .q     (z)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DEC_WIDTH; gi++) begin : g_dec
      assign dec[gi] = en & (int'(sel) == gi);
    end
  endgenerate

endmodule

// File: tb/tb_alu_flag_deco.sv
// Self-checking bench for alu_flag_deco: directed corner cases followed by
// randomized traffic compared against an arithmetic reference model.
module tb_alu_flag_deco;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       op_alu;
  logic             wez;
  logic [1:0]       sel;
  logic             en;
  logic [WIDTH-1:0] y;
  logic             zalu;
  logic             z;
  logic [3:0]       dec;

  int   checks   = 0;
  int   failures = 0;
  logic z_model  = 1'b0;

  alu_flag_deco #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .op_alu (op_alu),
    .wez    (wez),
    .sel    (sel),
    .en     (en),
    .y      (y),
    .zalu   (zalu),
    .z      (z),
    .dec    (dec)
  );

  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic reduced modulo 2^WIDTH.
  function automatic int ref_y(int ai, int bi, int op);
    int r;
    case (op)
      0:       r = ai;
      1:       r = MOD - 1 - ai;
      2:       r = (ai + bi) % MOD;
      3:       r = (ai - bi + MOD) % MOD;
      4:       r = ai & bi;
      5:       r = ai | bi;
      6:       r = (MOD - ai) % MOD;
      default: r = (MOD - bi) % MOD;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    int exp_y;
    logic [3:0] exp_dec;
    exp_y   = ref_y(int'(a), int'(b), int'(op_alu));
    exp_dec = en ? 4'(1 << sel) : 4'b0000;
    chk({tag, ".y"}, 32'(y), 32'(exp_y));
    chk({tag, ".zalu"}, 32'(zalu), 32'(exp_y == 0));
    chk({tag, ".dec"}, 32'(dec), 32'(exp_dec));
  endtask

  // One rising edge; z follows the model from the inputs present at the edge.
  task automatic tick(input string tag);
    if (!reset)   z_model = 1'b0;
    else if (wez) z_model = (ref_y(int'(a), int'(b), int'(op_alu)) == 0);
    @(posedge clk);
    #1;
    chk({tag, ".z"}, 32'(z), 32'(z_model));
  endtask

  task automatic drive(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] op,
                       input logic we);
    a = ai; b = bi; op_alu = op; wez = we;
    #1;
  endtask

  initial begin
    reset = 1'b0; a = 8'h00; b = 8'h00; op_alu = 3'b000; wez = 1'b1; sel = 2'd0; en = 1'b0;
    #2;
    chk("reset.z", 32'(z), 32'd0);
    chk_comb("reset.comb");
    drive(8'h12, 8'h34, 3'b010, 1'b1);
    chk_comb("reset.add");
    @(negedge clk);
    reset = 1'b1;

    // Arithmetic wrap sets the flag after one edge.
    drive(8'hFF, 8'h01, 3'b010, 1'b1);
    chk("wrap.y", 32'(y), 32'h00);
    chk("wrap.zalu", 32'(zalu), 32'd1);
    tick("wrap");
    chk("wrap.z1", 32'(z), 32'd1);

    // Subtract and negate.
    drive(8'h05, 8'h07, 3'b011, 1'b0);
    chk("sub.y", 32'(y), 32'hFE);
    chk("sub.zalu", 32'(zalu), 32'd0);
    drive(8'h05, 8'h07, 3'b110, 1'b0);
    chk("nega.y", 32'(y), 32'hFB);
    drive(8'h05, 8'h07, 3'b111, 1'b0);
    chk("negb.y", 32'(y), 32'hF9);

    // Flag hold with nonzero result, then reload.
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      chk("hold.z1", 32'(z), 32'd1);
    end
    wez = 1'b1;
    tick("reload");
    chk("reload.z0", 32'(z), 32'd0);

    // Asynchronous reset mid-cycle.
    drive(8'h00, 8'h00, 3'b000, 1'b1);
    tick("preset");
    chk("preset.z1", 32'(z), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("async.z0", 32'(z), 32'd0);
    for (int i = 0; i < 2; i++) tick("inreset");
    chk("inreset.zalu", 32'(zalu), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick("release");
    chk("release.z1", 32'(z), 32'd1);

    // Decoder sweep.
    for (int e = 1; e >= 0; e--) begin
      for (int s = 0; s < 4; s++) begin
        en = e[0]; sel = 2'(s);
        #1;
        chk("dec", 32'(dec), e == 1 ? 32'(1 << s) : 32'd0);
      end
    end

    // Logic ops.
    drive(8'hF0, 8'h3C, 3'b100, 1'b0);
    chk("and.y", 32'(y), 32'h30);
    drive(8'hF0, 8'h3C, 3'b101, 1'b0);
    chk("or.y", 32'(y), 32'hFC);
    drive(8'hF0, 8'h3C, 3'b001, 1'b0);
    chk("not.y", 32'(y), 32'h0F);
    drive(8'hF0, 8'h3C, 3'b000, 1'b0);
    chk("pass.y", 32'(y), 32'hF0);

    // Randomized traffic; zero-biased operands exercise the flag path.
    for (int i = 0; i < 200; i++) begin
      sel = 2'($urandom_range(0, 3));
      en  = 1'($urandom_range(0, 1));
      drive(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      chk_comb("rand");
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        #1;
        z_model = 1'b0;
        chk("rand.async", 32'(z), 32'd0);
        tick("rand.inreset");
        @(negedge clk);
        reset = 1'b1;
        #1;
      end else begin
        tick("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
